// File: rtl/serial_add_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl_if
// Start/done handshake and operand/result bus between a parallel requester
// (master) and the bit-serial adder controller (slave).
//   start      : request, sampled by the controller only while idle
//   a, b, cin  : operands and carry-in, captured on the accepting edge
//   busy, done : controller status (busy in RUN and DONE, done for one cycle)
//   sum        : result register, qualified by done
//   cout, ovf  : unsigned carry-out and signed overflow of the last result
// ---------------------------------------------------------------------------
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial addition controller: feeds a single one-bit fulladder with a
// WIDTH-bit operand pair, LSB first, one bit per clock.
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset, priority over start
//   bus   : serial_add_ctrl_if slave modport (start/a/b/cin in,
//           busy/done/sum/cout/ovf out)
//
// state  | meaning
// -------+---------------------------------------------
// S_IDLE | waiting for start; result registers held
// S_RUN  | one operand bit added and shifted per cycle
// S_DONE | result presented, done high for one cycle
// ---------------------------------------------------------------------------

// One-bit full adder cell.
module fulladder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);
    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_add_ctrl_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic [CW-1:0]    r_cnt;
    logic             w_s;
    logic             w_cout;
    logic             w_last;

    fulladder u_fa (
        .A    (r_a_sh[0]),
        .B    (r_b_sh[0]),
        .Cin  (r_carry),
        .S    (w_s),
        .Cout (w_cout)
    );

    assign w_last = (r_cnt == LAST_BIT);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_RUN;
            S_RUN:   if (w_last)    w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a_sh  <= bus.a;
                        r_b_sh  <= bus.b;
                        r_carry <= bus.cin;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_sum   <= {w_s, r_sum[WIDTH-1:1]};
                    r_carry <= w_cout;
                    if (w_last) begin
                        // r_carry is the carry into the MSB at this point.
                        r_cout <= w_cout;
                        r_ovf  <= r_carry ^ w_cout;
                        r_cnt  <= '0;
                    end else begin
                        r_cnt  <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = (r_state == S_DONE);
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(8))  if8  ();
    serial_add_ctrl_if #(.WIDTH(13)) if13 ();

    serial_add_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_add_ctrl #(.WIDTH(13)) dut13 (.clk(clk), .rst_n(rst_n), .bus(if13));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one WIDTH=8 operation and wait for done. lat counts edges from
    // the accepting edge (inclusive) to the start of the done cycle.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       output int lat, output logic ok,
                       output logic busy1, output logic done1);
        int g = 0;
        while (if8.busy && g < 40) begin tick(); g++; end
        if8.a = a; if8.b = b; if8.cin = ci; if8.start = 1'b1;
        tick();
        if8.start = 1'b0;
        busy1 = if8.busy; done1 = if8.done;
        lat = 1;
        while (!if8.done && lat < 40) begin tick(); lat++; end
        ok = if8.done;
    endtask

    task automatic op13(input logic [12:0] a, input logic [12:0] b, input logic ci,
                        output logic ok);
        int g = 0;
        while (if13.busy && g < 40) begin tick(); g++; end
        if13.a = a; if13.b = b; if13.cin = ci; if13.start = 1'b1;
        tick();
        if13.start = 1'b0;
        g = 1;
        while (!if13.done && g < 40) begin tick(); g++; end
        ok = if13.done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if8.start = 0; if8.a = '0; if8.b = '0; if8.cin = 0;
        if13.start = 0; if13.a = '0; if13.b = '0; if13.cin = 0;
        repeat (3) tick();
        checks++;
        if ({if8.busy, if8.done, if8.cout, if8.ovf} !== 4'b0 || if8.sum !== 8'h00) begin
            failures++;
            $display("FAIL reset8: busy=%b done=%b cout=%b ovf=%b sum=%h, want all 0",
                     if8.busy, if8.done, if8.cout, if8.ovf, if8.sum);
        end
        checks++;
        if ({if13.busy, if13.done, if13.cout, if13.ovf} !== 4'b0 || if13.sum !== 13'h0) begin
            failures++;
            $display("FAIL reset13: busy=%b done=%b cout=%b ovf=%b sum=%h, want all 0",
                     if13.busy, if13.done, if13.cout, if13.ovf, if13.sum);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int lat; logic ok, b1, d1;
        op8(8'h5A, 8'h33, 1'b0, lat, ok, b1, d1);
        checks++;
        if (b1 !== 1'b1 || d1 !== 1'b0) begin
            failures++;
            $display("FAIL accept_status: busy=%b done=%b, want busy=1 done=0", b1, d1);
        end
        checks++;
        if (!ok || lat != 9) begin
            failures++;
            $display("FAIL done_latency: got %0d edges (done=%b), want 9", lat, ok);
        end
        checks++;
        if (if8.sum !== 8'h8D || if8.cout !== 1'b0 || if8.ovf !== 1'b1) begin
            failures++;
            $display("FAIL basic_result: sum=%h cout=%b ovf=%b, want 8d 0 1",
                     if8.sum, if8.cout, if8.ovf);
        end
        tick();
        checks++;
        if (if8.done !== 1'b0 || if8.busy !== 1'b0 || if8.sum !== 8'h8D || if8.ovf !== 1'b1) begin
            failures++;
            $display("FAIL post_done_hold: done=%b busy=%b sum=%h ovf=%b, want 0 0 8d 1",
                     if8.done, if8.busy, if8.sum, if8.ovf);
        end
    endtask

    task automatic test_carry_cases();
        int lat; logic ok, b1, d1;
        op8(8'hFF, 8'h01, 1'b0, lat, ok, b1, d1);
        checks++;
        if (!ok || if8.sum !== 8'h00 || if8.cout !== 1'b1 || if8.ovf !== 1'b0) begin
            failures++;
            $display("FAIL carry_wrap: done=%b sum=%h cout=%b ovf=%b, want 1 00 1 0",
                     ok, if8.sum, if8.cout, if8.ovf);
        end
        op8(8'h7F, 8'h00, 1'b1, lat, ok, b1, d1);
        checks++;
        if (!ok || if8.sum !== 8'h80 || if8.cout !== 1'b0 || if8.ovf !== 1'b1) begin
            failures++;
            $display("FAIL cin_overflow: done=%b sum=%h cout=%b ovf=%b, want 1 80 0 1",
                     ok, if8.sum, if8.cout, if8.ovf);
        end
    endtask

    task automatic test_ignore_start();
        int g = 0; int done_cnt = 0; int busy_cnt = 0; logic gap = 0; logic seen_busy_low = 0;
        while (if8.busy && g < 40) begin tick(); g++; end
        if8.a = 8'h10; if8.b = 8'h20; if8.cin = 0; if8.start = 1;
        tick();
        if8.start = 0;
        for (int lat = 1; lat <= 12; lat++) begin
            if (if8.busy) begin
                busy_cnt++;
                if (seen_busy_low) gap = 1;
            end else seen_busy_low = 1;
            if (if8.done) begin
                done_cnt++;
                checks++;
                if (if8.sum !== 8'h30 || lat != 9) begin
                    failures++;
                    $display("FAIL ignore_result: sum=%h at edge %0d, want 30 at 9", if8.sum, lat);
                end
            end
            // Disturbing requests during RUN (3) and DONE (9).
            if (lat == 3 || lat == 9) begin
                if8.a = 8'hC3; if8.b = 8'h5E; if8.cin = 1; if8.start = 1;
            end else begin
                if8.start = 0;
            end
            if (lat < 12) tick();
        end
        if8.start = 0;
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL ignore_done_pulses: got %0d, want 1", done_cnt);
        end
        checks++;
        if (busy_cnt != 9 || gap) begin
            failures++;
            $display("FAIL ignore_busy: high %0d cycles gap=%b, want 9 contiguous", busy_cnt, gap);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat; logic ok, b1, d1; int g = 0;
        while (if8.busy && g < 40) begin tick(); g++; end
        if8.a = 8'h5A; if8.b = 8'h33; if8.cin = 1; if8.start = 1;
        tick();
        if8.start = 0;
        repeat (4) tick();
        rst_n = 0;
        tick();
        checks++;
        if ({if8.busy, if8.done, if8.cout, if8.ovf} !== 4'b0 || if8.sum !== 8'h00) begin
            failures++;
            $display("FAIL mid_run_reset: busy=%b done=%b cout=%b ovf=%b sum=%h, want all 0",
                     if8.busy, if8.done, if8.cout, if8.ovf, if8.sum);
        end
        rst_n = 1;
        op8(8'h01, 8'h01, 1'b0, lat, ok, b1, d1);
        checks++;
        if (!ok || lat != 9 || if8.sum !== 8'h02 || if8.cout !== 1'b0 || if8.ovf !== 1'b0) begin
            failures++;
            $display("FAIL after_reset_op: done=%b lat=%0d sum=%h cout=%b ovf=%b, want 1 9 02 0 0",
                     ok, lat, if8.sum, if8.cout, if8.ovf);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] expq[$];
        logic [9:0] e;
        logic [8:0] t;
        logic prev_busy;
        int edge_n = 0; int last_acc = -1; int nres = 0; int g = 0;
        while (if8.busy && g < 40) begin tick(); g++; end
        prev_busy = if8.busy;
        if8.a = 8'($urandom()); if8.b = 8'($urandom()); if8.cin = 1'($urandom()); if8.start = 1;
        while (nres < 6 && edge_n < 200) begin
            tick();
            edge_n++;
            if (!prev_busy && if8.busy) begin
                if (last_acc >= 0) begin
                    checks++;
                    if (edge_n - last_acc != 10) begin
                        failures++;
                        $display("FAIL b2b_spacing: %0d edges, want 10", edge_n - last_acc);
                    end
                end
                last_acc = edge_n;
                t = {1'b0, if8.a} + {1'b0, if8.b} + {8'b0, if8.cin};
                e = {(if8.a[7] == if8.b[7]) && (t[7] != if8.a[7]), t};
                expq.push_back(e);
                if8.a = 8'($urandom()); if8.b = 8'($urandom()); if8.cin = 1'($urandom());
            end
            if (if8.done) begin
                nres++;
                checks++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_unexpected_done: got done, want none");
                end else begin
                    e = expq.pop_front();
                    if ({if8.ovf, if8.cout, if8.sum} !== e) begin
                        failures++;
                        $display("FAIL b2b_result: ovf,cout,sum=%h, want %h",
                                 {if8.ovf, if8.cout, if8.sum}, e);
                    end
                end
            end
            prev_busy = if8.busy;
        end
        if8.start = 0;
        checks++;
        if (nres != 6) begin
            failures++;
            $display("FAIL b2b_timeout: %0d results, want 6", nres);
        end
    endtask

    task automatic test_random8(input int n);
        int lat; logic ok, b1, d1;
        logic [7:0] a, b; logic ci; logic [8:0] t; logic eo;
        for (int i = 0; i < n; i++) begin
            a = 8'($urandom()); b = 8'($urandom()); ci = 1'($urandom());
            op8(a, b, ci, lat, ok, b1, d1);
            t  = {1'b0, a} + {1'b0, b} + {8'b0, ci};
            eo = (a[7] == b[7]) && (t[7] != a[7]);
            checks++;
            if (!ok || lat != 9 || {if8.cout, if8.sum} !== t || if8.ovf !== eo) begin
                failures++;
                $display("FAIL rand8: %h+%h+%b got done=%b lat=%0d cout,sum=%h ovf=%b, want 1 9 %h %b",
                         a, b, ci, ok, lat, {if8.cout, if8.sum}, if8.ovf, t, eo);
            end
        end
    endtask

    task automatic test_random13(input int n);
        logic ok;
        logic [12:0] a, b; logic ci; logic [13:0] t; logic eo;
        for (int i = 0; i < n; i++) begin
            a = 13'($urandom()); b = 13'($urandom()); ci = 1'($urandom());
            if (i == 0) begin a = 13'h1FFF; b = 13'h0000; ci = 1; end
            if (i == 1) begin a = 13'h0FFF; b = 13'h0001; ci = 0; end
            op13(a, b, ci, ok);
            t  = {1'b0, a} + {1'b0, b} + {13'b0, ci};
            eo = (a[12] == b[12]) && (t[12] != a[12]);
            checks++;
            if (!ok || {if13.cout, if13.sum} !== t || if13.ovf !== eo) begin
                failures++;
                $display("FAIL rand13: %h+%h+%b got done=%b cout,sum=%h ovf=%b, want 1 %h %b",
                         a, b, ci, ok, {if13.cout, if13.sum}, if13.ovf, t, eo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_cases();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        test_random8(1000);
        test_random13(1000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial addition controller that sequences the team's one-bit `fulladder` cell over a WIDTH-bit operand pair, LSB first, one bit per clock. It owns the operand shift registers, the carry flip-flop, the bit counter and a start/done handshake. It sits between a parallel requester and the single-bit adder datapath, trading latency for area.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range WIDTH >= 2.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  request pulse or level; sampled only in IDLE.
- `a`  in  WIDTH  operand A; captured on the edge that accepts `start`.
- `b`  in  WIDTH  operand B; captured with `a`.
- `cin`  in  1  carry-in; captured with `a` into the carry flip-flop.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  high for exactly one cycle in DONE.
- `sum`  out  WIDTH  result register; valid while `done` is high and held through IDLE.
- `cout`  out  1  unsigned carry-out of bit WIDTH-1.
- `ovf`  out  1  signed overflow: carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.

## Operation
- Exactly one `fulladder` instance: A = `a_sh[0]`, B = `b_sh[0]`, Cin = `carry_q`.
- States:
  - IDLE: wait for `start`.
  - RUN: process one bit per cycle.
  - DONE: present the result.
- IDLE -> RUN on an edge with `start`=1. On that edge:
  - `a_sh`<=`a`, `b_sh`<=`b`, `carry_q`<=`cin`, `cnt`<=0.
- RUN, each edge:
  - `a_sh`, `b_sh` shift right by one.
  - `sum` shifts right, with adder S entering at bit WIDTH-1.
  - `carry_q`<=adder Cout; `cnt`<=`cnt`+1.
- Final bit (`cnt`==WIDTH-1) also updates:
  - `cout`<=adder Cout.
  - `ovf`<=`carry_q` XOR adder Cout.
  - Next state is DONE.
- DONE -> IDLE unconditionally on the next edge.
- `start` is ignored in RUN and DONE; it is never queued.
- `cnt` width is $clog2(WIDTH). It never exceeds WIDTH-1.
- `sum` shows partial shift contents during RUN. Consumers qualify it with `done`.
- `sum`, `cout` and `ovf` hold their last value in IDLE until the next accepted `start` begins shifting. `cout` and `ovf` change only on the final-bit edge.
- `rst_n`=0 at any edge, including mid-RUN:
  - State goes to IDLE and the operation is aborted.
  - `sum`, `cout`, `ovf`, `carry_q`, `cnt`, `a_sh`, `b_sh` all go to 0.
  - Reset has priority over `start`.

## Timing
- Reset values: `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0.
- `start` accepted at edge k: `busy` rises after edge k.
- Bits are processed on edges k+1 through k+WIDTH.
- `done`=1 during the cycle after edge k+WIDTH. That cycle is WIDTH+1 edges after acceptance.
- State returns to IDLE after edge k+WIDTH+1. The earliest next acceptance is edge k+WIDTH+2.
- Throughput with `start` held high: one result per WIDTH+2 cycles.
- `busy` and `done` are registered-state decodes, with no combinational path from `start`.
- The adder is combinational within one cycle. The critical path is `fulladder` plus the carry flip-flop setup.

## Test plan
- WIDTH=8, `a`=0x5A, `b`=0x33, `cin`=0, one-cycle `start` -> `done` pulses 9 cycles after acceptance with `sum`=0x8D, `cout`=0, `ovf`=1.
- `a`=0xFF, `b`=0x01, `cin`=0 -> `sum`=0x00, `cout`=1, `ovf`=0. Then `a`=0x7F, `b`=0x00, `cin`=1 -> `sum`=0x80, `cout`=0, `ovf`=1.
- Start 0x10+0x20, then pulse `start` with different operands in cycles 3 and 9 (RUN and DONE) -> ignored; result is `sum`=0x30, `done` is a single pulse, `busy` is continuous.
- Drive `rst_n`=0 for one edge after 4 RUN cycles -> next cycle `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0. A fresh start of 0x01+0x01 then yields `sum`=0x02.
- Hold `start`=1 with operands changing every result -> acceptances exactly WIDTH+2 cycles apart; each `sum` matches the operands present on its acceptance edge.
- Random regression, WIDTH=8 and WIDTH=13, 1000 operations -> {`cout`,`sum`} == a+b+cin, and `ovf` matches the signed-overflow model.
